wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: req1_valid  input  1  requester 1 (ALU result) has a write pending.
REQ-004 SHALL have ports: req1_data  input  8  requester 1 write data.
REQ-005 SHALL have ports: req1_addr  input  3  requester 1 destination register.
REQ-006 SHALL have ports: req1_ready  output  1  requester 1 transfer accepted this cycle.
REQ-007 SHALL have ports: req2_valid, req2_data[7:0], req2_addr[2:0] inputs and req2_ready output, with the same meaning for requester 2 (load result).
REQ-008 SHALL have ports: sel  output  1  select for the shared 8-bit 2:1 write-data mux (0 = requester 1 data, 1 = requester 2 data).
REQ-009 SHALL have ports: out_valid  output  1  registered write-port request valid.
REQ-010 SHALL have ports: out_data  output  8  registered write data.
REQ-011 SHALL have ports: out_addr  output  3  registered destination register.
REQ-012 SHALL have ports: out_src  output  1  registered source of the current output (0 = req1, 1 = req2).
REQ-013 SHALL have ports: out_ready  input  1  register file consumes the output this cycle.

Function
REQ-014 SHALL define load = ~out_valid | out_ready; a transfer occurs on reqN when reqN_valid & reqN_ready.
REQ-015 SHALL compute grant combinationally; at most one of req1_ready, req2_ready SHALL be high, and reqN_ready = grantN & load.
REQ-016 SHALL drive sel = 1 exactly when requester 2 is granted, otherwise sel = 0.
REQ-017 SHALL, when exactly one requester is valid, grant that requester.
REQ-018 SHALL, when both are valid, resolve per REQ-028/REQ-029.
REQ-019 SHALL, on a transfer, register the granted data, addr and src into out_data, out_addr and out_src and set out_valid = 1 at the next edge, giving 1-cycle latency.
REQ-020 SHALL, on a clock edge with load = 1 and no transfer, clear out_valid and hold out_data, out_addr and out_src.
REQ-021 SHALL, while out_valid = 1 and out_ready = 0, hold all out_* stable and deassert both readys (no loss, no overwrite).
REQ-022 SHALL allow back-to-back transfers: with out_ready = 1 every cycle, one transfer per cycle.
REQ-023 SHALL treat reqN_data and reqN_addr as don't-care while reqN_valid = 0.
REQ-024 SHALL update the round-robin pointer only on a transfer, never on an idle or stalled cycle.

Reset
REQ-025 SHALL, while rst = 1 regardless of clk, force out_valid = 0, out_data = 8'h00, out_addr = 3'd0, out_src = 0, and rr_ptr = 0 (requester 1 preferred).
REQ-026 SHALL, on reset asserted mid-operation, discard the pending output; requesters SHALL see no transfer in that cycle, because readys are forced 0 while rst = 1.
REQ-027 SHALL accept a transfer on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro WB_ARB_ROUND_ROBIN_EN defined, resolve simultaneous requests round-robin:
- rr_ptr names the preferred requester.
- After a transfer from requester N, rr_ptr points to the other requester.
REQ-029 SHALL, without WB_ARB_ROUND_ROBIN_EN, use fixed priority: requester 2 (load) always wins on conflict, and no rr_ptr register is implemented.

Verification
REQ-030 SHALL cover reset: hold rst=1 with req1_valid=1 -> out_valid=0, out_data=00, req1_ready=0; deassert rst -> first edge loads req1 data.
REQ-031 SHALL cover single requester: req1 {data=8'h5A, addr=3}, out_ready=1 -> next cycle out_valid=1, out_data=5A, out_addr=3, out_src=0; sel=0 during the request.
REQ-032 SHALL cover conflict: both valid every cycle (req1=8'h11, req2=8'h22), out_ready=1 -> with WB_ARB_ROUND_ROBIN_EN the outputs are 11, 22, 11, 22; without it the outputs are 22, 22, 22.
REQ-033 SHALL cover backpressure: out_valid=1 with out_data=8'hA5, out_ready=0 for 3 cycles -> out_* stable, both readys 0; out_ready=1 -> next pending transfer accepted.
REQ-034 SHALL cover drain: single transfer 8'h7E followed by no requests, out_ready=1 -> out_valid=1 for one cycle then 0, out_data holds 7E.
REQ-035 SHALL cover mid-operation reset: rst pulsed while out_valid=1 and both requests pending -> out_valid=0 immediately; rr_ptr=0, so the first post-reset conflict grants req1 (round-robin build).

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the two requester channels, the shared write-mux select and the
// registered write-port output of wb_port_arbiter.
interface wb_port_arbiter_if;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic [2:0] req1_addr;
  logic       req1_ready;

  logic       req2_valid;
  logic [7:0] req2_data;
  logic [2:0] req2_addr;
  logic       req2_ready;

  logic       sel;

  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_addr;
  logic       out_src;
  logic       out_ready;

  // Requesters and the register file side.
  modport master (
    output req1_valid, req1_data, req1_addr,
    input  req1_ready,
    output req2_valid, req2_data, req2_addr,
    input  req2_ready,
    input  sel,
    input  out_valid, out_data, out_addr, out_src,
    output out_ready
  );

  // The arbiter itself.
  modport slave (
    input  req1_valid, req1_data, req1_addr,
    output req1_ready,
    input  req2_valid, req2_data, req2_addr,
    output req2_ready,
    output sel,
    output out_valid, out_data, out_addr, out_src,
    input  out_ready
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester write-port arbiter with a one-entry registered output stage.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise requester 2 always wins.
module wb_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q,  out_data_d;
  logic [2:0] out_addr_q,  out_addr_d;
  logic       out_src_q,   out_src_d;

  logic       load;
  logic       prefer2;
  logic       grant1, grant2;
  logic       ready1, ready2;
  logic       xfer;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // rr_ptr_q = 1 means requester 2 is preferred on the next conflict.
  logic rr_ptr_q, rr_ptr_d;
  assign prefer2 = rr_ptr_q;
`else
  assign prefer2 = 1'b1;
`endif

  always_comb begin
    grant1 = bus.req1_valid & ~(bus.req2_valid & prefer2);
    grant2 = bus.req2_valid & (~bus.req1_valid | prefer2);
  end

  // Readys are held low during reset so no requester sees a phantom transfer.
  assign load   = ~out_valid_q | bus.out_ready;
  assign ready1 = grant1 & load & ~rst;
  assign ready2 = grant2 & load & ~rst;
  assign xfer   = ready1 | ready2;

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant2 ? bus.req2_data : bus.req1_data;
      out_addr_d  = grant2 ? bus.req2_addr : bus.req1_addr;
      out_src_d   = grant2;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // After serving requester 1 prefer requester 2, and vice versa.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = ready1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments, and every flop here
  // is reset because the output register is observable immediately after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_addr_q  <= 3'd0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.req1_ready = ready1;
  assign bus.req2_ready = ready2;
  assign bus.sel        = grant2;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_src    = out_src_q;

  a_one_ready : assert property (@(posedge clk) disable iff (rst) !(ready1 && ready2))
    else $error("both readys high");

  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) &&
                                           $stable(out_addr_q) && $stable(out_src_q)))
    else $error("output changed under backpressure");

endmodule
